// File: rtl/svc_axi_pkg.sv
// Shared AXI constants and the stream write master state type.
package svc_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_t;

endpackage

// File: rtl/svc_axi_burst_len.sv
// Burst sizing: take as many beats as remain, but never run past the next
// MAX_BURST-beat aligned boundary.
module svc_axi_burst_len
    import svc_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 16,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic [AXI_ADDR_WIDTH-1:0]      addr,
    input  logic [LEN_WIDTH-1:0]           remaining,
    output logic [$clog2(MAX_BURST):0]     burst_beats_c
);

    localparam int unsigned SIZE_W  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned MB_W    = $clog2(MAX_BURST);
    localparam int unsigned BEATS_W = MB_W + 1;

    logic [BEATS_W-1:0] offset;
    logic [BEATS_W-1:0] room;
    logic               unused_addr_bits;

    // Beat index within the current MAX_BURST window.
    if (MB_W == 0) begin : g_single_beat
        assign offset = '0;
    end else begin : g_multi_beat
        assign offset = BEATS_W'(addr[SIZE_W +: MB_W]);
    end

    assign room             = BEATS_W'(MAX_BURST) - offset;
    assign burst_beats_c    = (remaining < LEN_WIDTH'(room)) ? BEATS_W'(remaining) : room;
    assign unused_addr_bits = ^addr;

endmodule

// File: rtl/svc_axi_stream_wr.sv
// Stream-to-AXI4 write master: splits a transfer into aligned INCR bursts,
// one outstanding burst at a time, and pulses done at the end.
module svc_axi_stream_wr
    import svc_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 16,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   start_addr,
    input  logic [LEN_WIDTH-1:0]        start_beats,
    input  logic [AXI_ID_WIDTH-1:0]     start_id,
    output logic                        busy,
    output logic                        done,
    output logic                        error,

    input  logic                        s_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   s_data,
    output logic                        s_ready,

    output logic                        m_axi_awvalid,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    input  logic                        m_axi_awready,

    output logic                        m_axi_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_wready,

    input  logic                        m_axi_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready
);

    localparam int unsigned SIZE_W  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int unsigned BEATS_W = $clog2(MAX_BURST) + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'((2 ** SIZE_W) - 1);

    wr_state_t                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [BEATS_W-1:0]        burst_beats_q, burst_beats_d;
    logic [BEATS_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                      awvalid_q, awvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic                      bready_q, bready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic [AXI_ADDR_WIDTH-1:0] aligned_start;
    logic [AXI_ADDR_WIDTH-1:0] addr_after;
    logic [LEN_WIDTH-1:0]      rem_after;
    logic [AXI_ADDR_WIDTH-1:0] len_addr;
    logic [LEN_WIDTH-1:0]      len_rem;
    logic [BEATS_W-1:0]        next_beats_c;

    assign aligned_start = start_addr & ALIGN_MASK;
    assign addr_after    = cur_addr_q + AXI_ADDR_WIDTH'(burst_beats_q * STRB_W);
    assign rem_after     = remaining_q - LEN_WIDTH'(burst_beats_q);

    // Size the burst that the next AW will carry, before entering AW.
    always_comb begin
        len_addr = cur_addr_q;
        len_rem  = remaining_q;
        if (state_q == ST_IDLE) begin
            len_addr = aligned_start;
            len_rem  = start_beats;
        end else if (state_q == ST_B) begin
            len_addr = addr_after;
            len_rem  = rem_after;
        end
    end

    svc_axi_burst_len #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .MAX_BURST      (MAX_BURST),
        .LEN_WIDTH      (LEN_WIDTH)
    ) u_burst_len (
        .addr          (len_addr),
        .remaining     (len_rem),
        .burst_beats_c (next_beats_c)
    );

    // W channel is a straight pass-through of the stream while in W.
    assign m_axi_wvalid  = (state_q == ST_W) && s_valid;
    assign s_ready       = (state_q == ST_W) && m_axi_wready;
    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == ST_W) && (beat_cnt_q == burst_beats_q - 1'b1);

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SIZE_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        id_d          = id_q;
        burst_beats_d = burst_beats_q;
        beat_cnt_d    = beat_cnt_q;
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        bready_d      = bready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (start_beats != '0) begin
                        cur_addr_d    = aligned_start;
                        remaining_d   = start_beats;
                        id_d          = start_id;
                        busy_d        = 1'b1;
                        awvalid_d     = 1'b1;
                        awaddr_d      = aligned_start;
                        awlen_d       = 8'(next_beats_c - 1'b1);
                        burst_beats_d = next_beats_c;
                        state_d       = ST_AW;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    awvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (m_axi_wvalid && m_axi_wready) begin
                    if (m_axi_wlast) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_B: begin
                if (m_axi_bvalid && bready_q) begin
                    if ((m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != id_q)) begin
                        error_d = 1'b1;
                    end
                    cur_addr_d  = addr_after;
                    remaining_d = rem_after;
                    bready_d    = 1'b0;
                    if (rem_after == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        awvalid_d     = 1'b1;
                        awaddr_d      = addr_after;
                        awlen_d       = 8'(next_beats_c - 1'b1);
                        burst_beats_d = next_beats_c;
                        state_d       = ST_AW;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            id_q          <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            bready_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            id_q          <= id_d;
            burst_beats_q <= burst_beats_d;
            beat_cnt_q    <= beat_cnt_d;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            bready_q      <= bready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

endmodule

// File: tb/tb_svc_axi_stream_wr.sv
// Bench for svc_axi_stream_wr: AXI subordinate + memory model with random
// stalls, stream source with gaps, and an arithmetic burst-split reference.
module tb_svc_axi_stream_wr;

    localparam int MB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] start_beats = '0;
    logic [3:0]  start_id = '0;
    logic        busy, done, error;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        m_axi_awvalid;
    logic [3:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awready = 1'b0;
    logic        m_axi_wvalid;
    logic [15:0] m_axi_wdata;
    logic [1:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bvalid = 1'b0;
    logic [3:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bready;

    svc_axi_stream_wr dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .start_addr(start_addr), .start_beats(start_beats), .start_id(start_id),
        .busy(busy), .done(done), .error(error),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          beats;
        int          errb;
        int          pct;
        bit          busy_start;
        int          data_base;
        int          exp_n;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } aw_rec_t;

    int tests = 0;
    int fails = 0;

    logic [15:0] src_q[$];
    logic [15:0] exp_data[$];
    aw_rec_t     obs_aw[$];
    aw_rec_t     exp_aw[$];
    logic [15:0] mem[int];
    int          aw_pct = 0, w_pct = 0, gap_pct = 0;
    int          err_burst = -1, burst_idx = 0, done_cnt = 0, w_cnt = 0;
    bit          w_active = 0, b_pending = 0, s_hold = 0, aw_stalled = 0;
    logic [7:0]  w_len = '0;
    logic [15:0] w_ptr = '0;
    logic [1:0]  b_resp_v = '0;
    logic [3:0]  last_id = '0;
    aw_rec_t     prev_aw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference split: walk the transfer, each burst stops at the next 16-beat boundary.
    task automatic model_bursts(input logic [15:0] addr, input int beats, input logic [3:0] id);
        int a, rem, idx, n;
        aw_rec_t r;
        exp_aw.delete();
        a   = int'(addr) & 32'hFFFE;
        rem = beats;
        while (rem > 0) begin
            idx = a / 2;
            n   = MB - (idx % MB);
            if (n > rem) n = rem;
            r.addr  = 16'(a);
            r.len   = 8'(n - 1);
            r.size  = 3'd1;
            r.burst = 2'b01;
            r.id    = id;
            exp_aw.push_back(r);
            a   = (a + 2 * n) % 65536;
            rem = rem - n;
        end
    endtask

    // Subordinate, memory and stream source: drive at negedge, sample 1 ns later.
    initial begin : bus
        aw_rec_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                src_q.delete();
                s_hold = 0; w_active = 0; b_pending = 0; aw_stalled = 0;
                s_valid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            end else begin
                m_axi_awready = ($urandom_range(99) >= aw_pct);
                m_axi_wready  = ($urandom_range(99) >= w_pct);
                if (!s_hold) begin
                    if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                        s_valid = 1'b1;
                        s_data  = src_q[0];
                    end else begin
                        s_valid = 1'b0;
                        s_data  = 16'($urandom);
                    end
                end
                if (!b_pending) begin
                    m_axi_bvalid = 1'b0;
                    m_axi_bresp  = 2'b00;
                    m_axi_bid    = 4'd0;
                end else if (!m_axi_bvalid) begin
                    m_axi_bvalid = ($urandom_range(99) >= w_pct);
                    m_axi_bresp  = b_resp_v;
                    m_axi_bid    = last_id;
                end
                #1;
                if (m_axi_awvalid) begin
                    r.addr = m_axi_awaddr; r.len = m_axi_awlen; r.size = m_axi_awsize;
                    r.burst = m_axi_awburst; r.id = m_axi_awid;
                    chk("aw_no_overlap", 64'(w_active || b_pending), 64'(0));
                    if (aw_stalled)
                        chk("aw_stable", {r.addr, r.len, r.size, r.burst, r.id},
                            {prev_aw.addr, prev_aw.len, prev_aw.size, prev_aw.burst, prev_aw.id});
                    if (m_axi_awready) begin
                        obs_aw.push_back(r);
                        w_active = 1; w_ptr = r.addr; w_cnt = 0; w_len = r.len; last_id = r.id;
                        aw_stalled = 0;
                    end else begin
                        aw_stalled = 1;
                        prev_aw = r;
                    end
                end
                if (s_ready) chk("s_ready_in_w", 64'(w_active), 64'(1));
                if (s_valid && s_ready) begin
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    s_hold = 0;
                end else begin
                    s_hold = s_valid;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    chk("w_in_burst", 64'(w_active), 64'(1));
                    chk("wlast", 64'(m_axi_wlast), 64'(w_cnt == int'(w_len)));
                    chk("wstrb", 64'(m_axi_wstrb), 64'(2'b11));
                    mem[int'(w_ptr[15:1])] = m_axi_wdata;
                    w_ptr = w_ptr + 16'd2;
                    if (w_cnt == int'(w_len)) begin
                        w_active  = 0;
                        b_pending = 1;
                        b_resp_v  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
                        burst_idx++;
                    end else begin
                        w_cnt++;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) b_pending = 0;
                if (done) done_cnt++;
            end
        end
    end

    task automatic run_xfer(input vec_t v, input string name);
        logic [3:0]  id;
        logic [15:0] base;
        int          k;
        logic [63:0] act;
        id = 4'($urandom_range(15));
        model_bursts(v.addr, v.beats, id);
        aw_pct = v.pct; w_pct = v.pct; gap_pct = v.pct;
        err_burst = v.errb; burst_idx = 0; done_cnt = 0;
        obs_aw.delete(); mem.delete(); exp_data.delete();
        @(negedge clk);
        for (int i = 0; i < v.beats; i++) begin
            exp_data.push_back((v.data_base >= 0) ? 16'(v.data_base + i) : 16'($urandom));
            src_q.push_back(exp_data[i]);
        end
        start = 1'b1; start_addr = v.addr; start_beats = 16'(v.beats); start_id = id;
        @(negedge clk);
        start = 1'b0; start_addr = 16'($urandom); start_beats = 16'($urandom); start_id = 4'($urandom);
        #2;
        chk({name, ":busy_after_start"}, 64'(busy), 64'(v.beats > 0));
        chk({name, ":error_cleared"}, 64'(error), 64'(0));
        if (v.beats == 0) chk({name, ":done_next_cycle"}, 64'(done), 64'(1));
        for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (v.busy_start && c == 2 && busy) begin
                start = 1'b1; start_addr = 16'h0300; start_beats = 16'd7;
            end else begin
                start = 1'b0;
            end
            #2;
        end
        start = 1'b0;
        chk({name, ":done_seen"}, 64'(done_cnt > 0), 64'(1));
        if (done_cnt == 0) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (4) @(negedge clk);
        #2;
        chk({name, ":done_once"}, 64'(done_cnt), 64'(1));
        chk({name, ":idle_busy"}, 64'(busy), 64'(0));
        chk({name, ":error"}, 64'(error), 64'(v.exp_err));
        chk({name, ":burst_count"}, 64'(obs_aw.size()), 64'(v.exp_n));
        for (int i = 0; i < obs_aw.size() && i < exp_aw.size(); i++)
            chk({name, ":aw_fields"},
                {obs_aw[i].addr, obs_aw[i].len, obs_aw[i].size, obs_aw[i].burst, obs_aw[i].id},
                {exp_aw[i].addr, exp_aw[i].len, exp_aw[i].size, exp_aw[i].burst, exp_aw[i].id});
        base = v.addr & 16'hFFFE;
        for (int i = 0; i < v.beats; i++) begin
            k   = (int'(base[15:1]) + i) % 32768;
            act = mem.exists(k) ? 64'(mem[k]) : 64'hDEAD_0000_0000;
            chk({name, ":mem"}, act, 64'(exp_data[i]));
        end
        chk({name, ":stream_drained"}, 64'(src_q.size()), 64'(0));
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        //          addr      beats errb pct busy_st base     n  err
        vecs[0] = '{16'h00A0,  4,  -1,  0, 0, 32'hD000, 1, 0};
        vecs[1] = '{16'h0000, 20,  -1,  0, 1, -1,       2, 0};
        vecs[2] = '{16'h001C,  5,  -1,  0, 0, -1,       2, 0};
        vecs[3] = '{16'h0000,  0,  -1,  0, 0, -1,       0, 0};
        vecs[4] = '{16'h0106, 37,  -1, 35, 0, -1,       3, 0};
        vecs[5] = '{16'h0000, 40,   1, 20, 0, -1,       3, 1};
        vecs[6] = '{16'h0003,  3,  -1,  0, 0, -1,       1, 0};
        vecs[7] = '{16'hFFF8,  8,  -1, 25, 0, -1,       2, 0};
        vecs[8] = '{16'h0010, 16,  -1, 10, 0, -1,       2, 0};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
        chk("rst_wvalid",  64'(m_axi_wvalid),  64'(0));
        chk("rst_bready",  64'(m_axi_bready),  64'(0));
        chk("rst_s_ready", 64'(s_ready),       64'(0));
        chk("rst_busy",    64'(busy),          64'(0));
        chk("rst_done",    64'(done),          64'(0));
        chk("rst_error",   64'(error),         64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a W burst abandons the transfer.
        aw_pct = 0; w_pct = 0; gap_pct = 0; done_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
        start = 1'b1; start_addr = 16'h0000; start_beats = 16'd20; start_id = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !(w_active && w_cnt >= 2); c++) begin
            @(negedge clk);
            #2;
        end
        chk("midw_reached", 64'(w_active && w_cnt >= 2), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("midw_awvalid", 64'(m_axi_awvalid), 64'(0));
        chk("midw_wvalid",  64'(m_axi_wvalid),  64'(0));
        chk("midw_bready",  64'(m_axi_bready),  64'(0));
        chk("midw_s_ready", 64'(s_ready),       64'(0));
        chk("midw_busy",    64'(busy),          64'(0));
        chk("midw_done",    64'(done),          64'(0));
        chk("midw_error",   64'(error),         64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        chk("midw_no_done", 64'(done_cnt), 64'(0));
        chk("midw_idle",    64'(busy),     64'(0));

        for (int t = 0; t < 6; t++) begin
            rv.addr = 16'($urandom);
            rv.beats = $urandom_range(1, 40);
            rv.errb = -1;
            rv.pct = $urandom_range(0, 40);
            rv.busy_start = 0;
            rv.data_base = -1;
            model_bursts(rv.addr, rv.beats, 4'd0);
            rv.exp_n = exp_aw.size();
            rv.exp_err = 0;
            run_xfer(rv, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
